// File: rtl/i2s_frame_sched.sv
// rtl/i2s_frame_sched.sv - I2S frame-boundary scheduler between the serial datapath and the DSP streams
module i2s_frame_sched #(
    parameter int WIDTH         = 32,
    parameter int CNT_WIDTH     = 16,
    parameter bit UNDERRUN_ZERO = 1'b1
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_cnt,
    input  logic                 lrck,
    input  logic [WIDTH-1:0]     pldout,
    input  logic [WIDTH-1:0]     prdout,
    output logic [WIDTH-1:0]     pldin,
    output logic [WIDTH-1:0]     prdin,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_ldata,
    output logic [WIDTH-1:0]     m_rdata,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_ldata,
    input  logic [WIDTH-1:0]     s_rdata,
    output logic                 frame_tick,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] overrun_cnt,
    output logic [CNT_WIDTH-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               state_q;
    logic                 lrck_q;
    logic                 m_valid_q;
    logic [WIDTH-1:0]     m_ldata_q;
    logic [WIDTH-1:0]     m_rdata_q;
    logic                 s_ready_q;
    logic                 staged_q;
    logic [WIDTH-1:0]     st_ldata_q;
    logic [WIDTH-1:0]     st_rdata_q;
    logic [WIDTH-1:0]     pldin_q;
    logic [WIDTH-1:0]     prdin_q;
    logic                 running_q;
    logic [CNT_WIDTH-1:0] ovr_cnt_q;
    logic [CNT_WIDTH-1:0] ovr_cnt_d;
    logic [CNT_WIDTH-1:0] und_cnt_q;
    logic [CNT_WIDTH-1:0] und_cnt_d;

    logic boundary;
    logic in_run;
    logic m_hs;
    logic s_hs;
    logic ovr_inc;
    logic und_inc;

    // Falling edge of lrck starts the left word; lrck_q resets low so no tick follows reset.
    assign boundary = lrck_q & ~lrck;
    assign in_run   = (state_q == ST_RUN) && en;
    assign m_hs     = m_valid_q & m_ready;
    assign s_hs     = s_valid & s_ready_q;
    assign ovr_inc  = in_run & boundary & m_valid_q & ~m_ready;
    assign und_inc  = in_run & boundary & ~staged_q;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        und_cnt_d = und_cnt_q;
        if (clr_cnt) begin
            ovr_cnt_d = '0;
            und_cnt_d = '0;
        end else begin
            if (ovr_inc && (ovr_cnt_q != {CNT_WIDTH{1'b1}}))
                ovr_cnt_d = ovr_cnt_q + CNT_WIDTH'(1);
            if (und_inc && (und_cnt_q != {CNT_WIDTH{1'b1}}))
                und_cnt_d = und_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lrck_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_ldata_q  <= '0;
            m_rdata_q  <= '0;
            s_ready_q  <= 1'b0;
            staged_q   <= 1'b0;
            st_ldata_q <= '0;
            st_rdata_q <= '0;
            pldin_q    <= '0;
            prdin_q    <= '0;
            running_q  <= 1'b0;
            ovr_cnt_q  <= '0;
            und_cnt_q  <= '0;
        end else begin
            lrck_q    <= lrck;
            ovr_cnt_q <= ovr_cnt_d;
            und_cnt_q <= und_cnt_d;
            if (!en) begin
                state_q   <= ST_IDLE;
                m_valid_q <= 1'b0;
                s_ready_q <= 1'b0;
                staged_q  <= 1'b0;
                pldin_q   <= '0;
                prdin_q   <= '0;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SYNC;
                    // First boundary only aligns: the receiver frame before it is partial.
                    ST_SYNC: begin
                        if (boundary) begin
                            state_q   <= ST_RUN;
                            pldin_q   <= '0;
                            prdin_q   <= '0;
                            s_ready_q <= 1'b1;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (boundary) begin
                            m_ldata_q <= pldout;
                            m_rdata_q <= prdout;
                            m_valid_q <= 1'b1;
                        end else if (m_hs) begin
                            m_valid_q <= 1'b0;
                        end
                        if (boundary && staged_q) begin
                            pldin_q   <= st_ldata_q;
                            prdin_q   <= st_rdata_q;
                            staged_q  <= 1'b0;
                            s_ready_q <= 1'b1;
                        end else begin
                            if (boundary && UNDERRUN_ZERO) begin
                                pldin_q <= '0;
                                prdin_q <= '0;
                            end
                            if (s_hs) begin
                                st_ldata_q <= s_ldata;
                                st_rdata_q <= s_rdata;
                                staged_q   <= 1'b1;
                                s_ready_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pldin        = pldin_q;
    assign prdin        = prdin_q;
    assign m_valid      = m_valid_q;
    assign m_ldata      = m_ldata_q;
    assign m_rdata      = m_rdata_q;
    assign s_ready      = s_ready_q;
    assign frame_tick   = boundary;
    assign running      = running_q;
    assign overrun_cnt  = ovr_cnt_q;
    assign underrun_cnt = und_cnt_q;

endmodule
